decode_stage: RTL and testbench

- Registered, parametrised RV32I/RV32E instruction decode stage placed between fetch and register-read/execute.
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Produces the opcode class one-hot, register indices, funct fields, one format-selected sign-extended immediate and an illegal-instruction flag.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path from out_ready to in_ready.

---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 237 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and the register-read consumer.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [9:0]      out_class;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class, out_rs1, out_rs2, out_rd,
           out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV32E decode stage with a 2-entry skid buffer so that in_ready
// comes straight from a flop and never depends combinationally on out_ready.
module decode_stage #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int CHECK_FUNCT7 = 1
) (
  input logic            clk,
  input logic            resetn,
  input logic            flush,
  decode_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } stateT;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [9:0]      cls;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entryT;

  localparam logic [5:0] RegLimit = 6'(NUM_REGS);

  stateT state;
  stateT nextState;
  logic  inReadyReg;
  entryT mainEntry;
  entryT skidEntry;
  entryT decoded;

  logic accept;
  logic drain;
  logic outValid;
  logic loadMainFromIn;
  logic loadMainFromSkid;
  logic loadSkid;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  logic signed [11:0] immI;
  logic signed [11:0] immS;
  logic signed [12:0] immB;
  logic signed [20:0] immJ;
  logic signed [31:0] immU;

  logic [9:0]      cls;
  logic            usesRd;
  logic            usesRs1;
  logic            usesRs2;
  logic            rdBad;
  logic            rs1Bad;
  logic            rs2Bad;
  logic            funct7Bad;
  logic            isIllegal;
  logic [XLEN-1:0] immSel;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign immI = instr[31:20];
  assign immS = {instr[31:25], instr[11:7]};
  assign immB = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign immJ = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign immU = {instr[31:12], 12'b0};

  assign rdBad  = ({1'b0, rd}  >= RegLimit);
  assign rs1Bad = ({1'b0, rs1} >= RegLimit);
  assign rs2Bad = ({1'b0, rs2} >= RegLimit);

  // Class bits: 0 ALUreg, 1 ALUimm, 2 Branch, 3 JALR, 4 JAL, 5 AUIPC, 6 LUI,
  // 7 Load, 8 Store, 9 SYSTEM.
  always_comb begin
    cls = '0;
    case (opcode)
      7'b0110011: cls[0] = 1'b1;
      7'b0010011: cls[1] = 1'b1;
      7'b1100011: cls[2] = 1'b1;
      7'b1100111: cls[3] = 1'b1;
      7'b1101111: cls[4] = 1'b1;
      7'b0010111: cls[5] = 1'b1;
      7'b0110111: cls[6] = 1'b1;
      7'b0000011: cls[7] = 1'b1;
      7'b0100011: cls[8] = 1'b1;
      7'b1110011: cls[9] = 1'b1;
      default:    cls    = '0;
    endcase
  end

  always_comb begin
    usesRd    = (cls != '0) && !cls[2] && !cls[8];
    usesRs1   = (cls != '0) && !cls[6] && !cls[5] && !cls[4];
    usesRs2   = cls[0] || cls[2] || cls[8];
    funct7Bad = 1'b0;
    if (CHECK_FUNCT7 != 0) begin
      if (cls[0]) begin
        funct7Bad = !((funct7 == 7'b0000000) ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end else if (cls[1] && funct3 == 3'b001) begin
        funct7Bad = (funct7 != 7'b0000000);
      end else if (cls[1] && funct3 == 3'b101) begin
        funct7Bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
    end
    isIllegal = (instr[1:0] != 2'b11) || (cls == '0) ||
                (usesRd && rdBad) || (usesRs1 && rs1Bad) || (usesRs2 && rs2Bad) ||
                funct7Bad;
  end

  always_comb begin
    immSel = '0;
    if (cls[6] || cls[5]) begin
      immSel = XLEN'(immU);
    end else if (cls[1] || cls[7] || cls[3] || cls[9]) begin
      immSel = XLEN'(immI);
    end else if (cls[8]) begin
      immSel = XLEN'(immS);
    end else if (cls[2]) begin
      immSel = XLEN'(immB);
    end else if (cls[4]) begin
      immSel = XLEN'(immJ);
    end
  end

  // Illegal entries keep their register and funct fields but report no class or immediate.
  always_comb begin
    decoded.pc      = bus.in_pc;
    decoded.cls     = isIllegal ? 10'b0 : cls;
    decoded.rs1     = rs1;
    decoded.rs2     = rs2;
    decoded.rd      = rd;
    decoded.funct3  = funct3;
    decoded.funct7  = funct7;
    decoded.imm     = isIllegal ? '0 : immSel;
    decoded.illegal = isIllegal;
  end

  assign outValid = (state != EMPTY);
  assign accept   = bus.in_valid && inReadyReg;
  assign drain    = outValid && bus.out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= EMPTY;
      inReadyReg <= 1'b0;
    end else begin
      state      <= nextState;
      inReadyReg <= (nextState != TWO);
    end
  end

  // Flush outranks everything; in TWO the skid entry slides into main as main drains.
  always_comb begin
    nextState        = state;
    loadMainFromIn   = 1'b0;
    loadMainFromSkid = 1'b0;
    loadSkid         = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            nextState      = ONE;
            loadMainFromIn = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            loadMainFromIn = 1'b1;
          end else if (accept) begin
            nextState = TWO;
            loadSkid  = 1'b1;
          end else if (drain) begin
            nextState = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            nextState        = ONE;
            loadMainFromSkid = 1'b1;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mainEntry <= '0;
      skidEntry <= '0;
    end else begin
      if (loadMainFromIn) begin
        mainEntry <= decoded;
      end else if (loadMainFromSkid) begin
        mainEntry <= skidEntry;
      end
      if (loadSkid) begin
        skidEntry <= decoded;
      end
    end
  end

  assign bus.in_ready    = inReadyReg;
  assign bus.out_valid   = outValid;
  assign bus.out_pc      = mainEntry.pc;
  assign bus.out_class   = mainEntry.cls;
  assign bus.out_rs1     = mainEntry.rs1;
  assign bus.out_rs2     = mainEntry.rs2;
  assign bus.out_rd      = mainEntry.rd;
  assign bus.out_funct3  = mainEntry.funct3;
  assign bus.out_funct7  = mainEntry.funct7;
  assign bus.out_imm     = mainEntry.imm;
  assign bus.out_illegal = mainEntry.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I instance and an RV32E instance run in
// lockstep on the same stimulus; a monitor checks every drained entry against the queue.
module tb_decode_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [9:0]  cls;
    logic [31:0] imm;
    logic        ill;
    logic [9:0]  cls16;
    logic [31:0] imm16;
    logic        ill16;
  } expT;

  logic clk = 1'b0;
  logic resetn;
  logic flush;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();
  decode_stage_if #(.XLEN(32)) bus16 ();

  assign bus16.in_valid  = bus.in_valid;
  assign bus16.in_instr  = bus.in_instr;
  assign bus16.in_pc     = bus.in_pc;
  assign bus16.out_ready = bus.out_ready;

  decode_stage #(.XLEN(32), .NUM_REGS(32), .CHECK_FUNCT7(1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  decode_stage #(.XLEN(32), .NUM_REGS(16), .CHECK_FUNCT7(1)) dut16 (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus16)
  );

  expT         sbQ[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] pcNext = 32'h0000_1000;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Holds the instruction until accepted; the expectation is queued before the accepting edge.
  task automatic applyStimulus(input logic [31:0] instr, input logic [9:0] cls,
                               input logic [31:0] imm, input logic ill,
                               input logic illegalOnlyIn16);
    expT e;
    bit  done = 1'b0;
    e.instr = instr;
    e.pc    = pcNext;
    e.cls   = cls;
    e.imm   = imm;
    e.ill   = ill;
    if (illegalOnlyIn16) begin
      e.cls16 = '0;
      e.imm16 = '0;
      e.ill16 = 1'b1;
    end else begin
      e.cls16 = cls;
      e.imm16 = imm;
      e.ill16 = ill;
    end
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pcNext;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.in_ready) begin
        sbQ.push_back(e);
        done = 1'b1;
      end
      step(1);
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept of 0x%0h", instr);
    end
    bus.in_valid = 1'b0;
    pcNext += 32'd4;
  endtask

  logic        held = 1'b0;
  logic [63:0] heldWide;
  logic [63:0] heldFields;

  // Monitor: samples mid-cycle, after the driver has settled inputs for the next edge.
  always begin
    expT e;
    @(negedge clk);
    #2;
    if (!resetn || flush) begin
      held = 1'b0;
    end else begin
      if (held && bus.out_valid) begin
        checkOutput("stable_pc_imm", {bus.out_pc, bus.out_imm}, heldWide);
        checkOutput("stable_fields",
                    64'({bus.out_class, bus.out_rs1, bus.out_rs2, bus.out_rd,
                         bus.out_funct3, bus.out_funct7, bus.out_illegal}), heldFields);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got pc 0x%0h expected no entry", bus.out_pc);
        end else begin
          e = sbQ.pop_front();
          checkOutput("pc",        bus.out_pc,      e.pc);
          checkOutput("class",     bus.out_class,   e.cls);
          checkOutput("imm",       bus.out_imm,     e.imm);
          checkOutput("illegal",   bus.out_illegal, e.ill);
          checkOutput("rd",        bus.out_rd,      e.instr[11:7]);
          checkOutput("rs1",       bus.out_rs1,     e.instr[19:15]);
          checkOutput("rs2",       bus.out_rs2,     e.instr[24:20]);
          checkOutput("funct3",    bus.out_funct3,  e.instr[14:12]);
          checkOutput("funct7",    bus.out_funct7,  e.instr[31:25]);
          checkOutput("valid16",   bus16.out_valid, 1);
          checkOutput("class16",   bus16.out_class, e.cls16);
          checkOutput("imm16",     bus16.out_imm,   e.imm16);
          checkOutput("illegal16", bus16.out_illegal, e.ill16);
        end
      end
      held       = bus.out_valid && !bus.out_ready;
      heldWide   = {bus.out_pc, bus.out_imm};
      heldFields = 64'({bus.out_class, bus.out_rs1, bus.out_rs2, bus.out_rd,
                        bus.out_funct3, bus.out_funct7, bus.out_illegal});
    end
  end

  initial begin
    resetn        = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    step(3);
    checkOutput("reset_in_ready",  bus.in_ready,  0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_pc",    bus.out_pc,    0);
    checkOutput("reset_out_imm",   bus.out_imm,   0);
    checkOutput("reset_out_class", bus.out_class, 0);
    resetn = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", bus.in_ready, 0);
    step(1);
    checkOutput("ready_after_first_edge", bus.in_ready, 1);

    $display("[TB] streaming decode vectors");
    bus.out_ready = 1'b1;
    applyStimulus(32'h0050_0093, 10'h002, 32'h0000_0005, 1'b0, 1'b0);
    checkOutput("latency_valid", bus.out_valid, 1);
    checkOutput("latency_rd",    bus.out_rd,    1);
    applyStimulus(32'h1234_52B7, 10'h040, 32'h1234_5000, 1'b0, 1'b0);
    applyStimulus(32'hFE00_0EE3, 10'h004, 32'hFFFF_FFFC, 1'b0, 1'b0);
    applyStimulus(32'h0080_00EF, 10'h010, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(32'h4020_81B3, 10'h001, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(32'h4050_5093, 10'h002, 32'h0000_0405, 1'b0, 1'b0);
    applyStimulus(32'hFFC1_2283, 10'h080, 32'hFFFF_FFFC, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_F097, 10'h020, 32'hFFFF_F000, 1'b0, 1'b0);
    applyStimulus(32'h0000_0073, 10'h200, 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(32'h4050_1093, 10'h000, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(32'h0000_0000, 10'h000, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(32'h4000_1033, 10'h000, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(32'h0000_0813, 10'h002, 32'h0000_0000, 1'b0, 1'b1);
    step(4);
    checkOutput("stream_drained", sbQ.size(), 0);

    $display("[TB] backpressure into the skid entry");
    bus.out_ready = 1'b0;
    applyStimulus(32'h0020_A423, 10'h100, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(32'h0050_0093, 10'h002, 32'h0000_0005, 1'b0, 1'b0);
    checkOutput("two_in_ready",  bus.in_ready,  0);
    checkOutput("two_out_valid", bus.out_valid, 1);
    step(3);
    bus.out_ready = 1'b1;
    step(4);
    checkOutput("backpressure_drained", sbQ.size(), 0);

    $display("[TB] flush while full");
    bus.out_ready = 1'b0;
    applyStimulus(32'h0080_00EF, 10'h010, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(32'h1234_52B7, 10'h040, 32'h1234_5000, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0050_0093;
    bus.in_pc    = 32'h0000_DEA0;
    flush        = 1'b1;
    sbQ.delete();
    step(1);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_out_valid", bus.out_valid, 0);
    checkOutput("flush_in_ready",  bus.in_ready,  1);
    bus.out_ready = 1'b1;
    step(5);
    checkOutput("flush_stays_empty", bus.out_valid, 0);

    $display("[TB] reset while full");
    bus.out_ready = 1'b0;
    applyStimulus(32'h0020_A423, 10'h100, 32'h0000_0008, 1'b0, 1'b0);
    applyStimulus(32'hFE00_0EE3, 10'h004, 32'hFFFF_FFFC, 1'b0, 1'b0);
    resetn = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("midreset_out_valid", bus.out_valid, 0);
    checkOutput("midreset_in_ready",  bus.in_ready,  0);
    checkOutput("midreset_out_pc",    bus.out_pc,    0);
    step(1);
    checkOutput("midreset_hold_ready", bus.in_ready, 0);
    resetn = 1'b1;
    #1;
    checkOutput("release_ready_before_edge", bus.in_ready, 0);
    step(1);
    checkOutput("release_ready_after_edge", bus.in_ready,  1);
    checkOutput("release_out_valid",        bus.out_valid, 0);
    bus.out_ready = 1'b1;
    step(4);
    checkOutput("reset_no_stale", bus.out_valid, 0);

    applyStimulus(32'h0020_A423, 10'h100, 32'h0000_0008, 1'b0, 1'b0);
    step(3);
    checkOutput("final_drained", sbQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
